// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - exhaustive truth-table sweep checker for a combinational gate under test
// Optional feature macro: CHECKER_STOP_ON_FAIL_EN (end the sweep at the first mismatch)
module truth_table_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic              dut_out,
    output logic [N_IN-1:0]   dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_vec
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    // One spare bit so the last-vector compare can never alias a wrapped count.
    localparam logic [N_IN:0] VEC_LAST = (N_IN + 1)'((1 << N_IN) - 1);

    logic [1:0]       state;
    logic [N_IN:0]    vec;
    logic [CNT_W-1:0] settle_cnt;
    logic [2:0]       op_q;
    logic             ref_bit;
    logic             mismatch;
    logic             err_sat;

    assign dut_in   = vec[N_IN-1:0];
    assign busy     = (state == DRIVE) || (state == CHECK);
    assign done     = (state == DONE);
    assign mismatch = (dut_out != ref_bit);
    assign err_sat  = &err_count;

    always_comb begin
        ref_bit = 1'b0;
        case (op_q)
            3'd0:    ref_bit = &vec[N_IN-1:0];
            3'd1:    ref_bit = |vec[N_IN-1:0];
            3'd2:    ref_bit = ~&vec[N_IN-1:0];
            3'd3:    ref_bit = ~|vec[N_IN-1:0];
            3'd4:    ref_bit = ^vec[N_IN-1:0];
            3'd5:    ref_bit = ~^vec[N_IN-1:0];
            3'd6:    ref_bit = vec[0];
            default: ref_bit = ~vec[0];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            op_q             <= 3'd0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q             <= op;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        pass             <= 1'b0;
                        vec              <= '0;
                        settle_cnt       <= '0;
                        state            <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == CNT_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (!err_sat) begin
                            err_count <= err_count + ERR_W'(1);
                        end
                        if (!first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec[N_IN-1:0];
                        end
                    end
`ifdef CHECKER_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        pass  <= 1'b0;
                        state <= DONE;
                    end else if (vec == VEC_LAST) begin
                        pass  <= (err_count == '0);
                        state <= DONE;
                    end else begin
                        vec   <= vec + (N_IN + 1)'(1);
                        state <= DRIVE;
                    end
`else
                    if (vec == VEC_LAST) begin
                        // Count is still zero only if this last check also matched.
                        pass  <= (err_count == '0) && !mismatch;
                        state <= DONE;
                    end else begin
                        vec   <= vec + (N_IN + 1)'(1);
                        state <= DRIVE;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
